// File: rtl/mem_access_if.sv
// Bus bundle for the memory-access stage: EX-side handshake, data-memory req/ack and WB outputs.
// The master modport is the stage itself; the slave modport is its environment (EX, memory, WB).
interface mem_access_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [31:0]       inst;
  logic [4:0]        inst_type;
  logic [31:0]       result;
  logic [DATA_W-1:0] operand_b;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              wb_valid;
  logic              wb_en;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;

  modport master (
    input  valid, inst, inst_type, result, operand_b, mem_ack, mem_rdata,
    output ready, mem_req, mem_we, mem_addr, mem_wdata,
    output wb_valid, wb_en, wb_rd, wb_data
  );

  modport slave (
    output valid, inst, inst_type, result, operand_b, mem_ack, mem_rdata,
    input  ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  wb_valid, wb_en, wb_rd, wb_data
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access stage of the 5-stage RISC pipeline: issues loads/stores over req/ack, stalls EX while busy.
// Optional macro MEM_MISALIGN_CHECK_EN adds misalign_err and suppresses requests for unaligned word accesses.
module mem_access #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_if.master     bus,
  output logic [CNT_W-1:0] stall_cnt
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic             misalign_err
`endif
);

  localparam logic [4:0] T_IMM   = 5'b00100;
  localparam logic [4:0] T_REG   = 5'b01100;
  localparam logic [4:0] T_LOAD  = 5'b00000;
  localparam logic [4:0] T_STORE = 5'b01000;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [4:0] rd_p1;
  logic [4:0] rd_p0;
  logic       mis_addr;
  logic       unused_inst_bits;

  function automatic logic is_alu(input logic [4:0] t);
    return (t == T_IMM) || (t == T_REG);
  endfunction

  function automatic logic is_mem(input logic [4:0] t);
    return (t == T_LOAD) || (t == T_STORE);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  assign rd_p0            = bus.inst[11:7];
  assign unused_inst_bits = ^{bus.inst[31:12], bus.inst[6:0]};

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis_addr = (bus.result[1:0] != 2'b00);
`else
  assign mis_addr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rd_p1         <= '0;
      bus.ready     <= 1'b1;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.wb_valid  <= 1'b0;
      bus.wb_en     <= 1'b0;
      bus.wb_rd     <= '0;
      bus.wb_data   <= '0;
      stall_cnt     <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_err  <= 1'b0;
`endif
    end else begin
      bus.wb_valid <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
      case (state)
        // p0 -> p1: accept from EX; ALU/branch retire next cycle, memory ops launch a request
        IDLE: begin
          if (bus.valid) begin
            if (is_mem(bus.inst_type) && !mis_addr) begin
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= (bus.inst_type == T_STORE);
              bus.mem_addr  <= ADDR_W'(bus.result);
              bus.mem_wdata <= (bus.inst_type == T_STORE) ? bus.operand_b : '0;
              rd_p1         <= rd_p0;
              bus.ready     <= 1'b0;
              state         <= BUSY;
            end else begin
              bus.wb_valid <= 1'b1;
              bus.wb_rd    <= rd_p0;
              if (is_alu(bus.inst_type)) begin
                bus.wb_en   <= (rd_p0 != 5'd0);
                bus.wb_data <= DATA_W'(bus.result);
              end else begin
                bus.wb_en   <= 1'b0;
                bus.wb_data <= '0;
              end
`ifdef MEM_MISALIGN_CHECK_EN
              misalign_err <= is_mem(bus.inst_type);
`endif
            end
          end
        end
        // p1 -> p2: hold the request until ack, then retire to WB
        BUSY: begin
          stall_cnt <= sat_inc(stall_cnt);
          if (bus.mem_ack) begin
            bus.mem_req  <= 1'b0;
            bus.ready    <= 1'b1;
            state        <= IDLE;
            bus.wb_valid <= 1'b1;
            bus.wb_rd    <= rd_p1;
            if (!bus.mem_we) begin
              bus.wb_en   <= (rd_p1 != 5'd0);
              bus.wb_data <= bus.mem_rdata;
            end else begin
              bus.wb_en   <= 1'b0;
              bus.wb_data <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed vectors, queued WB/memory expectations, negedge monitors.
`timescale 1ns/1ps
module tb_mem_access;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam logic [4:0] T_IMM   = 5'b00100;
  localparam logic [4:0] T_REG   = 5'b01100;
  localparam logic [4:0] T_LOAD  = 5'b00000;
  localparam logic [4:0] T_STORE = 5'b01000;
  localparam logic [4:0] T_BR    = 5'b11000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CNT_W-1:0] stall_cnt;
`ifdef MEM_MISALIGN_CHECK_EN
  logic             misalign_err;
`endif

  mem_access_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  mem_access #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.master),
    .stall_cnt(stall_cnt)
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic        chk_rd;
    logic        mis;
  } wb_exp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  wb_exp_t  wb_q[$];
  mem_exp_t mem_q[$];
  int errors = 0;
  int checks = 0;

  int          ack_delay = 0;
  logic        force_ack = 1'b0;
  logic [31:0] rdata_cfg = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wb(input logic en, input logic [4:0] rd, input logic [31:0] data,
                         input logic chk_data, input logic chk_rd, input logic mis);
    wb_exp_t e;
    e.en = en; e.rd = rd; e.data = data; e.chk_data = chk_data; e.chk_rd = chk_rd; e.mis = mis;
    wb_q.push_back(e);
  endtask

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    mem_exp_t m;
    m.we = we; m.addr = addr; m.wdata = wdata;
    mem_q.push_back(m);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with valid still high.
  task automatic issue(input logic [4:0] typ, input logic [4:0] rd, input logic [31:0] res,
                       input logic [31:0] opb, output int waits);
    bus.valid     = 1'b1;
    bus.inst_type = typ;
    bus.inst      = {7'h00, 5'd2, 5'd1, 3'd0, rd, 7'h33};
    bus.result    = res;
    bus.operand_b = opb;
    waits = 0;
    while (bus.ready !== 1'b1 && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: waited %0d cycles, limit 200", waits);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic count_req(output int n, output int rdy_bad);
    n = 0;
    rdy_bad = 0;
    while (bus.mem_req === 1'b1 && n < 100) begin
      n++;
      if (bus.ready !== 1'b0) rdy_bad++;
      @(negedge clk);
    end
  endtask

  // WB scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.wb_valid === 1'b1) begin
        wb_exp_t e;
        if (wb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: pulse with wb_data 0x%0h, none expected", bus.wb_data);
        end else begin
          e = wb_q.pop_front();
          check("wb_en", bus.wb_en, e.en);
          if (e.chk_rd) check("wb_rd", bus.wb_rd, e.rd);
          if (e.chk_data) check("wb_data", bus.wb_data, e.data);
`ifdef MEM_MISALIGN_CHECK_EN
          check("wb_misalign", misalign_err, e.mis);
`endif
        end
      end
    end
  end

  // Memory responder and request checker
  initial begin
    int       seen;
    mem_exp_t cur;
    seen = 0;
    cur = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        seen++;
        if (seen == 1) begin
          if (mem_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_unexpected: request addr 0x%0h, none expected", bus.mem_addr);
          end else begin
            cur = mem_q.pop_front();
            check("mem_we", bus.mem_we, cur.we);
            check("mem_addr", bus.mem_addr, cur.addr);
            check("mem_wdata", bus.mem_wdata, cur.wdata);
          end
        end else begin
          check("mem_addr_stable", bus.mem_addr, cur.addr);
          check("mem_we_stable", bus.mem_we, cur.we);
        end
      end else begin
        seen = 0;
      end
      bus.mem_ack   = force_ack || (bus.mem_req === 1'b1 && seen > ack_delay);
      bus.mem_rdata = bus.mem_ack ? rdata_cfg : 32'h0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n, rb;
    bus.valid = 1'b0; bus.inst = '0; bus.inst_type = '0; bus.result = '0; bus.operand_b = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_wb_data", bus.wb_data, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", bus.ready, 1);

    // Reset while a load is outstanding
    ack_delay = 100;
    push_mem(1'b0, 32'h200, 32'h0);
    issue(T_LOAD, 5'd3, 32'h200, 32'h55, w);
    bus.valid = 1'b0;
    check("busy_req", bus.mem_req, 1);
    check("busy_ready", bus.ready, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstbusy_req", bus.mem_req, 0);
    check("rstbusy_wbv", bus.wb_valid, 0);
    check("rstbusy_cnt", stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 0;
    #1;
    check("rstbusy_ready", bus.ready, 1);
    force_ack = 1'b1;
    @(negedge clk);
    #1 force_ack = 1'b0;
    @(negedge clk);
    check("late_ack_req", bus.mem_req, 0);
    check("late_ack_ready", bus.ready, 1);

    // Three back-to-back ALU ops
    push_wb(1'b1, 5'd5, 32'd10, 1'b1, 1'b1, 1'b0);
    push_wb(1'b1, 5'd6, 32'd20, 1'b1, 1'b1, 1'b0);
    push_wb(1'b0, 5'd0, 32'd30, 1'b1, 1'b1, 1'b0);
    issue(T_REG, 5'd5, 32'd10, 32'h0, w);
    check("add0_waits", w, 0);
    check("add0_wbv", bus.wb_valid, 1);
    issue(T_REG, 5'd6, 32'd20, 32'h0, w);
    check("add1_waits", w, 0);
    check("add1_wbv", bus.wb_valid, 1);
    issue(T_REG, 5'd0, 32'd30, 32'h0, w);
    bus.valid = 1'b0;
    check("add2_waits", w, 0);
    check("add2_wbv", bus.wb_valid, 1);
    @(negedge clk);
    check("add_idle_wbv", bus.wb_valid, 0);

    // Load with three wait states
    ack_delay = 3;
    rdata_cfg = 32'hDEADBEEF;
    push_mem(1'b0, 32'h100, 32'h0);
    push_wb(1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
    issue(T_LOAD, 5'd7, 32'h100, 32'h99, w);
    bus.valid = 1'b0;
    count_req(n, rb);
    check("ld_req_cycles", n, 4);
    check("ld_ready_low", rb, 0);
    check("ld_wb_pulse", bus.wb_valid, 1);
    check("ld_stall_cnt", stall_cnt, 4);
    @(negedge clk);
    check("ld_wbv_drop", bus.wb_valid, 0);
    check("ld_wb_hold", bus.wb_data, 32'hDEADBEEF);

    // Zero-wait store
    ack_delay = 0;
    push_mem(1'b1, 32'h40, 32'h1234);
    push_wb(1'b0, 5'd9, 32'h0, 1'b1, 1'b0, 1'b0);
    issue(T_STORE, 5'd9, 32'h40, 32'h1234, w);
    bus.valid = 1'b0;
    count_req(n, rb);
    check("st_req_cycles", n, 1);
    check("st_wb_pulse", bus.wb_valid, 1);
    check("st_stall_cnt", stall_cnt, 5);

    // Branch, spurious ack in IDLE, then a normal load
    push_wb(1'b0, 5'd4, 32'h0, 1'b1, 1'b0, 1'b0);
    issue(T_BR, 5'd4, 32'h80, 32'h0, w);
    bus.valid = 1'b0;
    check("br_wbv", bus.wb_valid, 1);
    #1 force_ack = 1'b1;
    @(negedge clk);
    #1 force_ack = 1'b0;
    @(negedge clk);
    check("spur_req", bus.mem_req, 0);
    check("spur_ready", bus.ready, 1);
    ack_delay = 1;
    rdata_cfg = 32'hCAFE0001;
    push_mem(1'b0, 32'h104, 32'h0);
    push_wb(1'b1, 5'd12, 32'hCAFE0001, 1'b1, 1'b1, 1'b0);
    issue(T_LOAD, 5'd12, 32'h104, 32'h0, w);
    bus.valid = 1'b0;
    count_req(n, rb);
    check("ld2_req_cycles", n, 2);
    check("ld2_wb_pulse", bus.wb_valid, 1);
    check("ld2_stall_cnt", stall_cnt, 7);

    // Instruction held behind a load is taken in the IDLE cycle after return
    ack_delay = 0;
    rdata_cfg = 32'h0BADF00D;
    push_mem(1'b0, 32'h10, 32'h0);
    push_wb(1'b1, 5'd1, 32'h0BADF00D, 1'b1, 1'b1, 1'b0);
    push_wb(1'b1, 5'd2, 32'h77, 1'b1, 1'b1, 1'b0);
    issue(T_LOAD, 5'd1, 32'h10, 32'h0, w);
    issue(T_IMM, 5'd2, 32'h77, 32'h0, w);
    bus.valid = 1'b0;
    check("held_waits", w, 1);
    check("held_wbv", bus.wb_valid, 1);
    check("held_stall_cnt", stall_cnt, 8);

    // Long wait saturates the stall counter; load to x0 does not write
    ack_delay = 20;
    rdata_cfg = 32'h5A5A5A5A;
    push_mem(1'b0, 32'h300, 32'h0);
    push_wb(1'b0, 5'd0, 32'h5A5A5A5A, 1'b1, 1'b1, 1'b0);
    issue(T_LOAD, 5'd0, 32'h300, 32'h0, w);
    bus.valid = 1'b0;
    count_req(n, rb);
    check("sat_req_cycles", n, 21);
    check("sat_stall_cnt", stall_cnt, 15);
    ack_delay = 0;
    push_mem(1'b1, 32'h44, 32'hA5);
    push_wb(1'b0, 5'd3, 32'h0, 1'b1, 1'b0, 1'b0);
    issue(T_STORE, 5'd3, 32'h44, 32'hA5, w);
    bus.valid = 1'b0;
    count_req(n, rb);
    check("sat_hold_cnt", stall_cnt, 15);

`ifdef MEM_MISALIGN_CHECK_EN
    push_wb(1'b0, 5'd7, 32'h0, 1'b0, 1'b0, 1'b1);
    issue(T_LOAD, 5'd7, 32'h102, 32'h0, w);
    bus.valid = 1'b0;
    check("mis_req", bus.mem_req, 0);
    check("mis_ready", bus.ready, 1);
    check("mis_wbv", bus.wb_valid, 1);
    check("mis_err", misalign_err, 1);
    @(negedge clk);
    check("mis_err_drop", misalign_err, 0);
    check("mis_req_after", bus.mem_req, 0);
`else
    rdata_cfg = 32'h11112222;
    push_mem(1'b0, 32'h102, 32'h0);
    push_wb(1'b1, 5'd7, 32'h11112222, 1'b1, 1'b1, 1'b0);
    issue(T_LOAD, 5'd7, 32'h102, 32'h0, w);
    bus.valid = 1'b0;
    check("unal_req", bus.mem_req, 1);
    @(negedge clk);
    check("unal_wbv", bus.wb_valid, 1);
`endif

    repeat (3) @(negedge clk);
    check("wb_q_empty", wb_q.size(), 0);
    check("mem_q_empty", mem_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
